player_sequence_checker: RTL and testbench
==========================================

# player_sequence_checker

Receive side of the colour-sequence game. The sequence datapath generates a 15-bit target of five 3-bit colours and plays it out. This block collects the player's five colour entries into a sequence with the same packing, then compares them against the target. It reports match/fail, the first wrong slot, and an inactivity timeout to the game FSM.

## Interface
Parameters:
- NUM_COLOURS, 5: colours per round; fixed at 5 for the 15-bit target.
- COLOUR_W, 3: bits per colour.
- TIMEOUT_CYCLES, 50000000: maximum number of idle cycles between accepted entries. 0 disables the timeout.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  begin a round; honoured only in IDLE.
- target  in  15  expected sequence; slot i occupies [3i+2:3i]; captured on accepted start.
- colour_in  in  3  player colour.
- colour_valid  in  1  one-cycle entry strobe qualifying colour_in.
- busy  out  1  high whenever state is not IDLE.
- count  out  3  number of accepted entries in this round (0..5).
- entered  out  15  collected entries, slot-packed like target.
- done  out  1  one-cycle pulse when the round result is valid.
- match  out  1  entered equals the captured target; held until the next accepted start.
- timed_out  out  1  round ended by timeout; held until the next accepted start.
- fail_index  out  3  index (0..4) of the lowest mismatching slot; 3'd7 if none; held.

## Operation
- States: IDLE, COLLECT, CHECK, RESULT.
- IDLE:
  - On start: capture target into tgt_q.
  - Clear entered, count, match, timed_out and the timer; set fail_index=7.
  - Go to COLLECT.
- COLLECT:
  - An entry is accepted when colour_valid=1 and colour_in≠3'b000. Colour 000 is the blank/idle colour: ignored, and it does not reset the timer.
  - On accept: write colour_in to slot count, increment count, clear the timer.
  - When count reaches 5 after an accept, go to CHECK.
  - If there is no accept and the timer equals TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES≠0), set timed_out=1 and go to CHECK.
  - Otherwise increment the timer.
- CHECK (one cycle):
  - match=1 only if timed_out=0 and entered==tgt_q.
  - fail_index = lowest i where the slots differ; if timed_out, fail_index = count; 7 if all five slots match.
  - Go to RESULT.
- RESULT (one cycle): done=1, then return to IDLE.
- Ignored inputs:
  - colour_valid outside COLLECT.
  - start outside IDLE.
  - Changes on target after capture.
- Width rules:
  - count saturates logically at 5; there is no write beyond slot 4.
  - The timer width is $clog2(TIMEOUT_CYCLES+1), minimum 1.
- Reset values: busy=0, count=0, entered=0, done=0, match=0, timed_out=0, fail_index=7; state IDLE; tgt_q=0.

## Timing
- start sampled at edge k: busy=1 and count=0 after edge k.
- Entry accepted at edge k: entered and count update after edge k. Back-to-back accepts on consecutive cycles are legal.
- Fifth accept at edge k: CHECK after k, done=1 after k+1, IDLE after k+2. Result latency is 2 cycles.
- Timeout: expiry at edge k gives done after k+1.
- An accept and timer expiry in the same cycle: the accept wins, the timer clears, and there is no timeout.
- Reset asserted mid-round: immediate return to IDLE with reset values. No done pulse.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- EARLY_FAIL_EN defined:
  - In COLLECT, each accepted entry is compared against its tgt_q slot in the same cycle.
  - On the first mismatch, record fail_index = that slot and go to CHECK immediately. count includes the wrong entry.
  - CHECK then keeps the recorded fail_index and sets match=0.
  - Latency from the wrong entry to done: 2 cycles.
- EARLY_FAIL_EN not defined: no per-entry comparison. All five entries, or a timeout, are always required before CHECK.

## Test plan
- Correct round: target=15'b101_100_011_010_001, start, then colours 1,2,3,4,5 on consecutive cycles -> entered=target, count=5, done pulse 2 cycles after the 5th entry, match=1, fail_index=7.
- Wrong slot: same target, colours 1,2,6,4,5 -> match=0, fail_index=2. With EARLY_FAIL_EN: done 2 cycles after the 3rd entry, count=3.
- Blank and stray strobes:
  - colour 000 with colour_valid -> count unchanged.
  - colour_valid in IDLE -> no effect.
  - start during COLLECT -> ignored; count preserved.
- Timeout (TIMEOUT_CYCLES=20): two entries, then silence -> timed_out=1, match=0, fail_index=2, done 21 cycles after the last entry's edge. An accept on the expiry cycle prevents the timeout.
- Target change after start: target altered mid-round to the entered value -> result still compared against the captured target.
- Async reset mid-round: assert reset between clock edges after the 3rd entry -> outputs go to reset values without waiting for an edge, and there is no done pulse. A fresh round afterwards completes normally.

Source files
------------

// File: rtl/player_sequence_checker.sv
// player_sequence_checker: collects five player colour entries, compares them
// against the captured target and reports match, first wrong slot and timeout.
// Optional feature: define EARLY_FAIL_EN to end the round on the first wrong entry.
module player_sequence_checker #(
    parameter int unsigned NUM_COLOURS    = 5,
    parameter int unsigned COLOUR_W       = 3,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic [NUM_COLOURS*COLOUR_W-1:0] target,
    input  logic [COLOUR_W-1:0]             colour_in,
    input  logic                            colour_valid,
    output logic                            busy,
    output logic [2:0]                      count,
    output logic [NUM_COLOURS*COLOUR_W-1:0] entered,
    output logic                            done,
    output logic                            match,
    output logic                            timed_out,
    output logic [2:0]                      fail_index
);

    localparam int unsigned SEQ_W   = NUM_COLOURS * COLOUR_W;
    localparam int unsigned TIMER_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST =
        TIMER_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic       TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [2:0] LAST_SLOT  = 3'(NUM_COLOURS - 1);
    localparam logic [2:0] NO_FAIL    = 3'd7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2,
        RESULT  = 2'd3
    } state_t;

    state_t               state_q;
    logic [SEQ_W-1:0]     tgt_q;
    logic [TIMER_W-1:0]   timer_q;
    logic                 early_q;

    logic                 accept_c;
    logic                 expired_c;
    logic [2:0]           first_diff_c;

    // Entry qualification: blank colour 000 is never an entry
    assign accept_c  = (state_q == COLLECT) && colour_valid && (colour_in != '0);
    assign expired_c = TIMEOUT_EN && (timer_q == TIMER_LAST);

    // Lowest slot where the collected entries differ from the captured target
    always_comb begin
        first_diff_c = NO_FAIL;
        for (int i = int'(NUM_COLOURS) - 1; i >= 0; i--) begin
            if (entered[i*COLOUR_W +: COLOUR_W] != tgt_q[i*COLOUR_W +: COLOUR_W]) begin
                first_diff_c = 3'(i);
            end
        end
    end

`ifdef EARLY_FAIL_EN
    logic [COLOUR_W-1:0] tgt_slot_c;

    // Target colour for the slot the next entry will land in
    always_comb begin
        tgt_slot_c = '0;
        for (int i = 0; i < int'(NUM_COLOURS); i++) begin
            if (count == 3'(i)) begin
                tgt_slot_c = tgt_q[i*COLOUR_W +: COLOUR_W];
            end
        end
    end
`endif

    // Round FSM with all outputs registered
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tgt_q      <= '0;
            timer_q    <= '0;
            early_q    <= 1'b0;
            busy       <= 1'b0;
            count      <= '0;
            entered    <= '0;
            done       <= 1'b0;
            match      <= 1'b0;
            timed_out  <= 1'b0;
            fail_index <= NO_FAIL;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        tgt_q      <= target;
                        entered    <= '0;
                        count      <= '0;
                        match      <= 1'b0;
                        timed_out  <= 1'b0;
                        timer_q    <= '0;
                        early_q    <= 1'b0;
                        fail_index <= NO_FAIL;
                        busy       <= 1'b1;
                        state_q    <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (accept_c) begin
                        for (int i = 0; i < int'(NUM_COLOURS); i++) begin
                            if (count == 3'(i)) begin
                                entered[i*COLOUR_W +: COLOUR_W] <= colour_in;
                            end
                        end
                        count   <= count + 3'd1;
                        timer_q <= '0;
`ifdef EARLY_FAIL_EN
                        if (colour_in != tgt_slot_c) begin
                            fail_index <= count;
                            early_q    <= 1'b1;
                            state_q    <= CHECK;
                        end else
`endif
                        if (count == LAST_SLOT) begin
                            state_q <= CHECK;
                        end
                    end else if (expired_c) begin
                        timed_out <= 1'b1;
                        state_q   <= CHECK;
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end
                CHECK: begin
                    match <= !timed_out && !early_q && (entered == tgt_q);
                    if (timed_out) begin
                        fail_index <= count;
                    end else if (!early_q) begin
                        fail_index <= first_diff_c;
                    end
                    done    <= 1'b1;
                    state_q <= RESULT;
                end
                RESULT: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_sequence_checker.sv
// Directed bench for player_sequence_checker (TIMEOUT_CYCLES=20).
// Expectations follow EARLY_FAIL_EN when the macro is defined for the build.
module tb_player_sequence_checker;

    localparam logic [14:0] TGT  = 15'b101_100_011_010_001;
    localparam logic [14:0] ONES = 15'b001_001_001_001_001;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [14:0] target = '0;
    logic [2:0]  colour_in = '0;
    logic        colour_valid = 1'b0;
    logic        busy;
    logic [2:0]  count;
    logic [14:0] entered;
    logic        done;
    logic        match;
    logic        timed_out;
    logic [2:0]  fail_index;

    int total = 0;
    int bad   = 0;

    player_sequence_checker #(
        .NUM_COLOURS   (5),
        .COLOUR_W      (3),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .target      (target),
        .colour_in   (colour_in),
        .colour_valid(colour_valid),
        .busy        (busy),
        .count       (count),
        .entered     (entered),
        .done        (done),
        .match       (match),
        .timed_out   (timed_out),
        .fail_index  (fail_index)
    );

    always #5 clock = ~clock;

    // Inputs change and outputs are sampled on the falling edge
    task automatic enter(input logic [2:0] c);
        colour_in = c; colour_valid = 1'b1;
        @(negedge clock);
        colour_valid = 1'b0; colour_in = '0;
    endtask

    task automatic begin_round(input logic [14:0] t);
        target = t; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clock);
            if (done === 1'b1) begin n = i; break; end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clock);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++; if (entered !== 15'd0) begin bad++; $display("FAIL reset_entered: got %h want 0", entered); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (match !== 1'b0 || timed_out !== 1'b0) begin bad++; $display("FAIL reset_flags: got match=%b timed_out=%b want 0 0", match, timed_out); end
        total++; if (fail_index !== 3'd7) begin bad++; $display("FAIL reset_fail_index: got %0d want 7", fail_index); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_correct;
        begin_round(TGT);
        total++; if (busy !== 1'b1 || count !== 3'd0) begin bad++; $display("FAIL correct_start: got busy=%b count=%0d want 1 0", busy, count); end
        enter(3'd1); enter(3'd2); enter(3'd3); enter(3'd4); enter(3'd5);
        total++; if (entered !== TGT) begin bad++; $display("FAIL correct_entered: got %b want %b", entered, TGT); end
        total++; if (count !== 3'd5 || done !== 1'b0) begin bad++; $display("FAIL correct_check_cycle: got count=%0d done=%b want 5 0", count, done); end
        @(negedge clock);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL correct_done: got %b want 1", done); end
        total++; if (match !== 1'b1 || fail_index !== 3'd7 || timed_out !== 1'b0) begin bad++; $display("FAIL correct_result: got match=%b fail=%0d to=%b want 1 7 0", match, fail_index, timed_out); end
        @(negedge clock);
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL correct_idle: got done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_stray;
        colour_in = 3'd3; colour_valid = 1'b1;
        @(negedge clock);
        colour_valid = 1'b0; colour_in = '0;
        total++; if (count !== 3'd5 || entered !== TGT || busy !== 1'b0) begin bad++; $display("FAIL stray_idle_strobe: got count=%0d entered=%b busy=%b want 5 %b 0", count, entered, busy, TGT); end
        begin_round(TGT);
        enter(3'd1);
        enter(3'd0);
        total++; if (count !== 3'd1) begin bad++; $display("FAIL stray_blank: got count=%0d want 1", count); end
        begin_round(15'h7fff);
        total++; if (count !== 3'd1 || busy !== 1'b1 || entered !== 15'b001) begin bad++; $display("FAIL stray_start_in_collect: got count=%0d busy=%b entered=%b want 1 1 001", count, busy, entered); end
        enter(3'd2); enter(3'd3); enter(3'd4); enter(3'd5);
        @(negedge clock);
        total++; if (done !== 1'b1 || match !== 1'b1) begin bad++; $display("FAIL stray_result: got done=%b match=%b want 1 1", done, match); end
        @(negedge clock);
    endtask

    task automatic test_wrong_slot;
        begin_round(TGT);
        enter(3'd1); enter(3'd2); enter(3'd6);
`ifdef EARLY_FAIL_EN
        @(negedge clock);
        total++; if (done !== 1'b1 || count !== 3'd3) begin bad++; $display("FAIL wrong_early_done: got done=%b count=%0d want 1 3", done, count); end
`else
        enter(3'd4); enter(3'd5);
        @(negedge clock);
        total++; if (done !== 1'b1 || count !== 3'd5) begin bad++; $display("FAIL wrong_done: got done=%b count=%0d want 1 5", done, count); end
`endif
        total++; if (match !== 1'b0 || fail_index !== 3'd2) begin bad++; $display("FAIL wrong_result: got match=%b fail=%0d want 0 2", match, fail_index); end
        @(negedge clock);
    endtask

    task automatic test_timeout;
        int n;
        begin_round(TGT);
        enter(3'd1); enter(3'd2);
        wait_done(40, n);
        total++; if (n != 21) begin bad++; $display("FAIL timeout_latency: got %0d cycles want 21", n); end
        total++; if (timed_out !== 1'b1 || match !== 1'b0) begin bad++; $display("FAIL timeout_flags: got to=%b match=%b want 1 0", timed_out, match); end
        total++; if (fail_index !== 3'd2 || count !== 3'd2) begin bad++; $display("FAIL timeout_index: got fail=%0d count=%0d want 2 2", fail_index, count); end
        @(negedge clock);
    endtask

    task automatic test_accept_on_expiry;
        begin_round(TGT);
        enter(3'd1);
        repeat (19) @(negedge clock);
        total++; if (busy !== 1'b1 || timed_out !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL expiry_edge_pre: got busy=%b to=%b done=%b want 1 0 0", busy, timed_out, done); end
        enter(3'd2);
        total++; if (timed_out !== 1'b0 || count !== 3'd2 || busy !== 1'b1) begin bad++; $display("FAIL expiry_accept_wins: got to=%b count=%0d busy=%b want 0 2 1", timed_out, count, busy); end
        enter(3'd3); enter(3'd4); enter(3'd5);
        @(negedge clock);
        total++; if (done !== 1'b1 || match !== 1'b1 || timed_out !== 1'b0) begin bad++; $display("FAIL expiry_result: got done=%b match=%b to=%b want 1 1 0", done, match, timed_out); end
        @(negedge clock);
    endtask

    task automatic test_target_change;
        begin_round(TGT);
        enter(3'd1);
        target = ONES;
`ifdef EARLY_FAIL_EN
        enter(3'd1);
        @(negedge clock);
        total++; if (done !== 1'b1 || count !== 3'd2) begin bad++; $display("FAIL target_change_done: got done=%b count=%0d want 1 2", done, count); end
`else
        enter(3'd1); enter(3'd1); enter(3'd1); enter(3'd1);
        @(negedge clock);
        total++; if (done !== 1'b1 || count !== 3'd5) begin bad++; $display("FAIL target_change_done: got done=%b count=%0d want 1 5", done, count); end
`endif
        total++; if (match !== 1'b0 || fail_index !== 3'd1) begin bad++; $display("FAIL target_change_result: got match=%b fail=%0d want 0 1", match, fail_index); end
        @(negedge clock);
    endtask

    task automatic test_async_reset;
        logic seen_done;
        begin_round(TGT);
        enter(3'd1); enter(3'd2); enter(3'd3);
        #2 reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || count !== 3'd0 || entered !== 15'd0) begin bad++; $display("FAIL async_reset_state: got busy=%b count=%0d entered=%b want 0 0 0", busy, count, entered); end
        total++; if (fail_index !== 3'd7 || match !== 1'b0 || timed_out !== 1'b0) begin bad++; $display("FAIL async_reset_result: got fail=%0d match=%b to=%b want 7 0 0", fail_index, match, timed_out); end
        seen_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (done !== 1'b0) seen_done = 1'b1;
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (done !== 1'b0) seen_done = 1'b1;
        end
        total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL async_reset_no_done: got done pulse=%b want 0", seen_done); end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_stray();
        test_wrong_slot();
        test_timeout();
        test_accept_on_expiry();
        test_target_change();
        test_async_reset();
        test_correct();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
